// File: rtl/demux_rr_pkg.sv
// ---------------------------------------------------------------------------
// demux_rr_pkg
// Shared constants and types for the round-robin demux dispatcher.
//   NUM_DEST : number of destinations behind the 1x4 demux
//   SEL_W    : width of a destination index
//   state_t  : dispatcher FSM state (ST_IDLE = empty, ST_SEND = item held)
//   next_ptr : round-robin successor of a destination index (wraps mod 4)
// ---------------------------------------------------------------------------
package demux_rr_pkg;

  localparam int NUM_DEST = 4;
  localparam int SEL_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // The index width equals log2(NUM_DEST), so plain overflow gives mod-4 wrap.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] cur);
    return cur + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// ---------------------------------------------------------------------------
// demux_rr_pick
// Combinational rotate-priority search: returns the first enabled destination
// found when scanning indices (ptr+k) mod 4 for k = 0..3.
//   mask  [3:0] in  : destination enable mask
//   ptr   [1:0] in  : index where the scan starts
//   idx   [1:0] out : chosen destination (only meaningful when found = 1)
//   found       out : at least one destination is enabled
// ---------------------------------------------------------------------------
module demux_rr_pick
  import demux_rr_pkg::*;
(
  input  logic [NUM_DEST-1:0] mask,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    idx,
  output logic                found
);

  // Mask rotated so that bit k corresponds to destination (ptr+k) mod 4.
  logic [NUM_DEST-1:0] w_rot;
  logic [SEL_W-1:0]    w_off;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEST; gi++) begin : g_rot
      assign w_rot[gi] = mask[ptr + SEL_W'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated mask wins; scanning downwards lets the
  // last assignment be the lowest offset.
  always_comb begin
    w_off = '0;
    for (int k = NUM_DEST - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SEL_W'(k);
      end
    end
  end

  assign idx   = ptr + w_off;
  assign found = |mask;

endmodule

// File: rtl/demux_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_rr_dispatcher
// Single-entry round-robin dispatcher sequencing an external 1x4 demux.
// One item is held at a time and offered to exactly one enabled destination;
// destinations take turns starting after the last one served.
//
// Parameters:
//   WIDTH : data width
//   CNT_W : width of the delivered-item counter (wraps silently)
// Ports:
//   clk       in        clock, rising edge
//   rst       in        synchronous active-high reset
//   en_mask   in  [3:0] destination enables, sampled at acceptance only
//   in_valid  in        input item present
//   in_ready  out       input accepted this cycle (combinational)
//   in_data   in  [W]   input item
//   out_valid out [3:0] one-hot offer to the selected destination, or zero
//   out_ready in  [3:0] destination accepts; only bit sel is looked at
//   out_data  out [W]   held item, shared by all destinations
//   sel       out [1:0] demux select / locked destination
//   xfer_cnt  out [C]   number of items delivered
// ---------------------------------------------------------------------------
module demux_rr_dispatcher
  import demux_rr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DEST-1:0] en_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    sel,
  output logic [CNT_W-1:0]    xfer_cnt
);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  logic             w_deliver;
  logic             w_slot_free;
  logic             w_accept;
  logic [SEL_W-1:0] w_pick_ptr;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_found;

  // Delivery only ever looks at the locked destination's ready bit.
  assign w_deliver   = (r_state == ST_SEND) && out_ready[r_sel];

  // The holding register is free if empty, or if it empties on this edge.
  assign w_slot_free = (r_state == ST_IDLE) || out_ready[r_sel];
  assign in_ready    = w_slot_free && w_pick_found;
  assign w_accept    = in_valid && in_ready;

  // When a delivery and an accept coincide, the new pick must already use
  // the post-delivery pointer (sel+1), not the stale r_ptr.
  assign w_pick_ptr  = (r_state == ST_SEND) ? next_ptr(r_sel) : r_ptr;

  demux_rr_pick u_pick (
    .mask  (en_mask),
    .ptr   (w_pick_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_deliver) begin
        r_ptr <= next_ptr(r_sel);
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= in_data;
            r_sel   <= w_pick_idx;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            // Back-to-back: refill in the same cycle the old item leaves.
            r_data  <= in_data;
            r_sel   <= w_pick_idx;
            r_state <= ST_SEND;
          end else if (w_deliver) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Demux-style decode of the registered select, gated by the state, so
  // out_valid has no combinational path from any input.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEST; gi++) begin : g_valid
      assign out_valid[gi] = (r_state == ST_SEND) && (r_sel == SEL_W'(gi));
    end
  endgenerate

  assign out_data = r_data;
  assign sel      = r_sel;
  assign xfer_cnt = r_cnt;

endmodule
